nfc_command_arbiter: RTL and testbench
======================================

NFC_COMMAND_ARBITER -- requirements
Module: nfc_command_arbiter

Interface
REQ-001 SHALL have parameters: NumberOfWays, default 4, NAND ways per channel; NumberOfCmds, default 4, command executors sharing the ACG; WatchdogCycles, default 32'd1000000, busy-timeout limit.
REQ-002 SHALL have one clock and a synchronous active-high reset: iSystemClock  in  1  clock; iReset  in  1  reset. All state changes on the rising edge of iSystemClock.
REQ-003 SHALL have these upstream ports: iCMDValid  in  1  command offered; oCMDReady  out  1  arbiter accepts a command.
REQ-004 SHALL have these executor-side ports: iCmd_Start  in  NumberOfCmds  per-executor opcode/target decode hit; iCmd_LastStep  in  NumberOfCmds  executor finished; oCmd_CMDValid  out  NumberOfCmds  gated iCMDValid.
REQ-005 SHALL have these executor drive ports: iCmd_ACG_Command  in  8*NumberOfCmds; iCmd_ACG_CommandOption  in  3*NumberOfCmds; iCmd_ACG_TargetWay  in  NumberOfWays*NumberOfCmds; iCmd_ACG_NumOfData  in  16*NumberOfCmds; iCmd_ACG_CASelect  in  NumberOfCmds; iCmd_ACG_CAData  in  40*NumberOfCmds. Slice k belongs to executor k.
REQ-006 SHALL return these ports to executors: oCmd_ACG_Ready  out  8*NumberOfCmds; oCmd_ACG_LastStep  out  8*NumberOfCmds.
REQ-007 SHALL have these ACG-side ports: oACG_Command  out  8; oACG_CommandOption  out  3; oACG_TargetWay  out  NumberOfWays; oACG_NumOfData  out  16; oACG_CASelect  out  1; oACG_CAData  out  40; iACG_Ready  in  8; iACG_LastStep  in  8.
REQ-008 SHALL have these status ports: oGrant  out  NumberOfCmds  one-hot owner; oBusy  out  1; oMultiHit  out  1  sticky; oNoHit  out  1  one-cycle pulse; oTimeout  out  1  sticky.

Function
REQ-009 SHALL implement an FSM with states IDLE, GRANT and RELEASE.
REQ-010 In IDLE: oCMDReady=1, oGrant=0, oCmd_CMDValid = {NumberOfCmds{iCMDValid}}.
REQ-011 IDLE->GRANT when iCMDValid & |iCmd_Start; the grant is the lowest-index set bit of iCmd_Start, latched the same edge.
REQ-012 When more than one iCmd_Start bit is set at acceptance, oMultiHit SHALL set and stay set until reset; the lowest index still wins.
REQ-013 iCMDValid with iCmd_Start==0 in IDLE SHALL pulse oNoHit for one cycle and stay in IDLE.
REQ-014 In GRANT: oCMDReady=0; oCmd_CMDValid=0; all oACG_* outputs SHALL equal the granted slice, combinationally, with zero-cycle latency.
REQ-015 In GRANT, oCmd_ACG_Ready and oCmd_ACG_LastStep slices SHALL equal iACG_Ready and iACG_LastStep for the granted index and 8'h00 for all others.
REQ-016 GRANT->RELEASE on iCmd_LastStep[grant]==1; the LastStep of ungranted executors SHALL be ignored.
REQ-017 In RELEASE (one cycle): oACG_Command=0, oACG_CASelect=1, all other oACG_* = 0, and all executor Ready/LastStep slices = 0; then RELEASE->IDLE.
REQ-018 In IDLE and RELEASE, oACG_* SHALL take the idle values of REQ-017.
REQ-019 oBusy SHALL be 1 in GRANT and RELEASE.
REQ-020 Command-to-grant latency SHALL be 1 cycle; LastStep-to-oCMDReady latency SHALL be 2 cycles.

Reset
REQ-021 Reset SHALL force state IDLE, oGrant=0, oMultiHit=0, oNoHit=0, oTimeout=0 and the watchdog counter to 0.
REQ-022 Reset asserted in GRANT SHALL drop the grant on the next edge and drive the ACG idle values immediately thereafter; there SHALL be no RELEASE cycle.

Configuration
REQ-023 Macro NFC_ARB_WATCHDOG_EN, when defined: a 32-bit counter SHALL clear on entering GRANT and increment each GRANT cycle. When it reaches WatchdogCycles: oTimeout sets (sticky) and the FSM SHALL go to RELEASE even without LastStep.
REQ-024 With NFC_ARB_WATCHDOG_EN undefined, there SHALL be no counter and oTimeout SHALL be tied to 0.

Structure
REQ-025 A shared package nfc_pkg SHALL hold the FSM state encoding, the ACG idle constants (command 8'h00, CAData 40'h0) and the ACG field widths (8/3/16/40).
REQ-026 The sub-module nfc_prio_encoder (lowest-set-bit one-hot plus index, parameterised width) SHALL perform the grant selection; the muxing SHALL stay inline.

Verification
REQ-027 Single executor: iCMDValid=1, iCmd_Start=4'b0100 -> next cycle oGrant=4'b0100, oCMDReady=0, oACG_Command equals executor 2's 8'h08.
REQ-028 Isolation: in GRANT of executor 2, iACG_Ready=8'hFF -> slice 2 reads 8'hFF and slices 0, 1 and 3 read 8'h00.
REQ-029 Multi-hit: iCmd_Start=4'b1010 -> grant 4'b0010 and oMultiHit=1 until reset.
REQ-030 Release timing: pulse iCmd_LastStep[1] -> one RELEASE cycle with oACG_Command=0 and CASelect=1, then oCMDReady=1; iCmd_LastStep[3] during the grant to 1 has no effect.
REQ-031 No hit: iCMDValid=1 with iCmd_Start=0 -> oNoHit pulses once and the FSM stays in IDLE.
REQ-032 Watchdog with WatchdogCycles=16 and macro defined: no LastStep -> RELEASE after 16 GRANT cycles and oTimeout=1. Mid-grant reset -> oGrant=0 and IDLE the next cycle.

Source files
------------

// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC command arbiter: FSM state encoding,
// ACG field widths and the values driven to the ACG while nobody owns it.
package nfc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int AcgCmdW     = 8;
    localparam int AcgOptW     = 3;
    localparam int AcgNumDataW = 16;
    localparam int AcgCADataW  = 40;
    localparam int AcgStepW    = 8;

    localparam logic [AcgCmdW-1:0]    AcgIdleCommand  = 8'h00;
    localparam logic [AcgCADataW-1:0] AcgIdleCAData   = 40'h0;
    localparam logic                  AcgIdleCASelect = 1'b1;

endpackage

// File: rtl/nfc_prio_encoder.sv
// Lowest-set-bit priority encoder: one-hot winner, its index, any-hit and
// more-than-one-hit flags.
module nfc_prio_encoder #(
    parameter  int Width = 4,
    localparam int IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] req_i,
    output logic [Width-1:0] onehot_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             hit_o,
    output logic             multi_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        onehot_o = '0;
        idx_o    = '0;
        // Scan from the top so the lowest set bit is the last (winning) assignment.
        for (int i = Width - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IdxW'(i);
            end
        end
    end

    assign hit_o   = |req_i;
    assign multi_o = |(req_i & (req_i - Width'(1)));

endmodule

// File: rtl/nfc_command_arbiter.sv
// Grants the shared ACG to one command executor at a time (IDLE/GRANT/RELEASE).
// Optional busy watchdog enabled by defining NFC_ARB_WATCHDOG_EN.
module nfc_command_arbiter
    import nfc_pkg::*;
#(
    parameter int          NumberOfWays   = 4,
    parameter int          NumberOfCmds   = 4,
    parameter int unsigned WatchdogCycles = 32'd1000000
) (
    input  logic                                iSystemClock,
    input  logic                                iReset,
    input  logic                                iCMDValid,
    output logic                                oCMDReady,
    input  logic [NumberOfCmds-1:0]             iCmd_Start,
    input  logic [NumberOfCmds-1:0]             iCmd_LastStep,
    output logic [NumberOfCmds-1:0]             oCmd_CMDValid,
    input  logic [8*NumberOfCmds-1:0]           iCmd_ACG_Command,
    input  logic [3*NumberOfCmds-1:0]           iCmd_ACG_CommandOption,
    input  logic [NumberOfWays*NumberOfCmds-1:0] iCmd_ACG_TargetWay,
    input  logic [16*NumberOfCmds-1:0]          iCmd_ACG_NumOfData,
    input  logic [NumberOfCmds-1:0]             iCmd_ACG_CASelect,
    input  logic [40*NumberOfCmds-1:0]          iCmd_ACG_CAData,
    output logic [8*NumberOfCmds-1:0]           oCmd_ACG_Ready,
    output logic [8*NumberOfCmds-1:0]           oCmd_ACG_LastStep,
    output logic [7:0]                          oACG_Command,
    output logic [2:0]                          oACG_CommandOption,
    output logic [NumberOfWays-1:0]             oACG_TargetWay,
    output logic [15:0]                         oACG_NumOfData,
    output logic                                oACG_CASelect,
    output logic [39:0]                         oACG_CAData,
    input  logic [7:0]                          iACG_Ready,
    input  logic [7:0]                          iACG_LastStep,
    output logic [NumberOfCmds-1:0]             oGrant,
    output logic                                oBusy,
    output logic                                oMultiHit,
    output logic                                oNoHit,
    output logic                                oTimeout
);

    arb_state_e              state_q, state_d;
    logic [NumberOfCmds-1:0] grant_q, grant_d;
    logic                    multi_hit_q, multi_hit_d;
    logic                    no_hit_q, no_hit_d;

    logic [NumberOfCmds-1:0] sel_onehot;
    logic                    sel_hit;
    logic                    sel_multi;
    logic                    accept;
    logic                    wd_expire;

    nfc_prio_encoder #(.Width(NumberOfCmds)) u_prio (
        .req_i    (iCmd_Start),
        .onehot_o (sel_onehot),
        .idx_o    (),
        .hit_o    (sel_hit),
        .multi_o  (sel_multi)
    );

    assign accept = (state_q == ST_IDLE) && iCMDValid && sel_hit;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        multi_hit_d = multi_hit_q;
        no_hit_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_GRANT;
                    grant_d     = sel_onehot;
                    multi_hit_d = multi_hit_q | sel_multi;
                end else if (iCMDValid) begin
                    no_hit_d = 1'b1;
                end
            end
            ST_GRANT: begin
                // Only the owner's LastStep can end the grant.
                if (|(iCmd_LastStep & grant_q) || wd_expire) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            multi_hit_q <= 1'b0;
            no_hit_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q     <= state_d;
            grant_q     <= grant_d;
            multi_hit_q <= multi_hit_d;
            no_hit_q    <= no_hit_d;
        end
    end

`ifdef NFC_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    assign wd_expire = (state_q == ST_GRANT) && (wd_cnt_q == WatchdogCycles - 32'd1);

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q | wd_expire;
        if (accept) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_GRANT) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign oTimeout  = 1'b0;
`endif

    // ACG mux: idle values unless GRANT, then the owner's slice straight through.
    always_comb begin
        oACG_Command       = AcgIdleCommand;
        oACG_CommandOption = '0;
        oACG_TargetWay     = '0;
        oACG_NumOfData     = '0;
        oACG_CASelect      = AcgIdleCASelect;
        oACG_CAData        = AcgIdleCAData;
        oCmd_ACG_Ready     = '0;
        oCmd_ACG_LastStep  = '0;
        if (state_q == ST_GRANT) begin
            for (int k = 0; k < NumberOfCmds; k++) begin
                if (grant_q[k]) begin
                    oACG_Command       = iCmd_ACG_Command[k*AcgCmdW +: AcgCmdW];
                    oACG_CommandOption = iCmd_ACG_CommandOption[k*AcgOptW +: AcgOptW];
                    oACG_TargetWay     = iCmd_ACG_TargetWay[k*NumberOfWays +: NumberOfWays];
                    oACG_NumOfData     = iCmd_ACG_NumOfData[k*AcgNumDataW +: AcgNumDataW];
                    oACG_CASelect      = iCmd_ACG_CASelect[k];
                    oACG_CAData        = iCmd_ACG_CAData[k*AcgCADataW +: AcgCADataW];
                    oCmd_ACG_Ready[k*AcgStepW +: AcgStepW]    = iACG_Ready;
                    oCmd_ACG_LastStep[k*AcgStepW +: AcgStepW] = iACG_LastStep;
                end
            end
        end
    end

    assign oCMDReady     = (state_q == ST_IDLE);
    assign oCmd_CMDValid = (state_q == ST_IDLE) ? {NumberOfCmds{iCMDValid}} : '0;
    assign oBusy         = (state_q != ST_IDLE);
    assign oGrant        = grant_q;
    assign oMultiHit     = multi_hit_q;
    assign oNoHit        = no_hit_q;

endmodule

// File: tb/tb_nfc_command_arbiter.sv
// Self-checking bench for nfc_command_arbiter: directed scenarios plus random
// transactions against a transaction-level model of grant ownership.
module tb_nfc_command_arbiter;

    localparam int          NC = 4;
    localparam int          NW = 4;
    localparam int unsigned WD = 16;
    localparam logic [71:0] ACG_IDLE = {8'h00, 3'h0, 4'h0, 16'h0, 1'b1, 40'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             iReset;
    logic             iCMDValid;
    logic             oCMDReady;
    logic [NC-1:0]    iCmd_Start;
    logic [NC-1:0]    iCmd_LastStep;
    logic [NC-1:0]    oCmd_CMDValid;
    logic [8*NC-1:0]  iCmd_ACG_Command;
    logic [3*NC-1:0]  iCmd_ACG_CommandOption;
    logic [NW*NC-1:0] iCmd_ACG_TargetWay;
    logic [16*NC-1:0] iCmd_ACG_NumOfData;
    logic [NC-1:0]    iCmd_ACG_CASelect;
    logic [40*NC-1:0] iCmd_ACG_CAData;
    logic [8*NC-1:0]  oCmd_ACG_Ready;
    logic [8*NC-1:0]  oCmd_ACG_LastStep;
    logic [7:0]       oACG_Command;
    logic [2:0]       oACG_CommandOption;
    logic [NW-1:0]    oACG_TargetWay;
    logic [15:0]      oACG_NumOfData;
    logic             oACG_CASelect;
    logic [39:0]      oACG_CAData;
    logic [7:0]       iACG_Ready;
    logic [7:0]       iACG_LastStep;
    logic [NC-1:0]    oGrant;
    logic             oBusy;
    logic             oMultiHit;
    logic             oNoHit;
    logic             oTimeout;

    // Executor-side payloads, one entry per executor.
    logic [7:0]  ex_cmd [NC];
    logic [2:0]  ex_opt [NC];
    logic [3:0]  ex_way [NC];
    logic [15:0] ex_nd  [NC];
    logic        ex_cas [NC];
    logic [39:0] ex_cad [NC];

    for (genvar k = 0; k < NC; k++) begin : g_pack
        assign iCmd_ACG_Command[k*8 +: 8]           = ex_cmd[k];
        assign iCmd_ACG_CommandOption[k*3 +: 3]     = ex_opt[k];
        assign iCmd_ACG_TargetWay[k*NW +: NW]       = ex_way[k];
        assign iCmd_ACG_NumOfData[k*16 +: 16]       = ex_nd[k];
        assign iCmd_ACG_CASelect[k]                 = ex_cas[k];
        assign iCmd_ACG_CAData[k*40 +: 40]          = ex_cad[k];
    end

    logic [71:0] dut_acg;
    assign dut_acg = {oACG_Command, oACG_CommandOption, oACG_TargetWay,
                      oACG_NumOfData, oACG_CASelect, oACG_CAData};

    nfc_command_arbiter #(
        .NumberOfWays   (NW),
        .NumberOfCmds   (NC),
        .WatchdogCycles (WD)
    ) dut (
        .iSystemClock           (clk),
        .iReset                 (iReset),
        .iCMDValid              (iCMDValid),
        .oCMDReady              (oCMDReady),
        .iCmd_Start             (iCmd_Start),
        .iCmd_LastStep          (iCmd_LastStep),
        .oCmd_CMDValid          (oCmd_CMDValid),
        .iCmd_ACG_Command       (iCmd_ACG_Command),
        .iCmd_ACG_CommandOption (iCmd_ACG_CommandOption),
        .iCmd_ACG_TargetWay     (iCmd_ACG_TargetWay),
        .iCmd_ACG_NumOfData     (iCmd_ACG_NumOfData),
        .iCmd_ACG_CASelect      (iCmd_ACG_CASelect),
        .iCmd_ACG_CAData        (iCmd_ACG_CAData),
        .oCmd_ACG_Ready         (oCmd_ACG_Ready),
        .oCmd_ACG_LastStep      (oCmd_ACG_LastStep),
        .oACG_Command           (oACG_Command),
        .oACG_CommandOption     (oACG_CommandOption),
        .oACG_TargetWay         (oACG_TargetWay),
        .oACG_NumOfData         (oACG_NumOfData),
        .oACG_CASelect          (oACG_CASelect),
        .oACG_CAData            (oACG_CAData),
        .iACG_Ready             (iACG_Ready),
        .iACG_LastStep          (iACG_LastStep),
        .oGrant                 (oGrant),
        .oBusy                  (oBusy),
        .oMultiHit              (oMultiHit),
        .oNoHit                 (oNoHit),
        .oTimeout               (oTimeout)
    );

    int   total = 0;
    int   bad   = 0;
    logic exp_multi   = 1'b0;
    logic exp_timeout = 1'b0;

    // ---------------- model helpers ----------------
    function automatic int lowest_bit(input logic [NC-1:0] m);
        for (int i = 0; i < NC; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [71:0] exp_acg(input int w);
        return {ex_cmd[w], ex_opt[w], ex_way[w], ex_nd[w], ex_cas[w], ex_cad[w]};
    endfunction

    function automatic logic [8*NC-1:0] exp_slices(input int w, input logic [7:0] v);
        logic [8*NC-1:0] r;
        r = '0;
        if (w >= 0) r[w*8 +: 8] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iCMDValid     = 1'b0;
        iCmd_Start    = '0;
        iCmd_LastStep = '0;
        iACG_Ready    = '0;
        iACG_LastStep = '0;
    endtask

    task automatic randomize_execs();
        for (int k = 0; k < NC; k++) begin
            ex_cmd[k] = 8'($urandom);
            ex_opt[k] = 3'($urandom);
            ex_way[k] = 4'($urandom);
            ex_nd[k]  = 16'($urandom);
            ex_cas[k] = 1'($urandom);
            ex_cad[k] = {8'($urandom), 32'($urandom)};
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        iReset = 1'b1;
        step();
        step();
        iReset      = 1'b0;
        exp_multi   = 1'b0;
        exp_timeout = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        #1;
        total++; if (oCMDReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", oCMDReady); end
        total++; if (oGrant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", oGrant); end
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", oBusy); end
        total++; if ({oMultiHit, oNoHit, oTimeout} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {oMultiHit, oNoHit, oTimeout}); end
        total++; if (dut_acg !== ACG_IDLE) begin bad++; $display("FAIL reset_acg_idle: got %h want %h", dut_acg, ACG_IDLE); end
        total++; if (oCmd_CMDValid !== 4'h0) begin bad++; $display("FAIL reset_cmdvalid: got %b want 0000", oCmd_CMDValid); end
        iCMDValid = 1'b1;
        #1;
        total++; if (oCmd_CMDValid !== 4'hF) begin bad++; $display("FAIL idle_cmdvalid_fanout: got %b want 1111", oCmd_CMDValid); end
        iCMDValid = 1'b0;
    endtask

    task automatic test_single_and_isolation();
        randomize_execs();
        ex_cmd[2] = 8'h08;
        iCMDValid  = 1'b1;
        iCmd_Start = 4'b0100;
        step();
        iCMDValid  = 1'b0;
        iCmd_Start = '0;
        #1;
        total++; if (oGrant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", oGrant); end
        total++; if (oCMDReady !== 1'b0) begin bad++; $display("FAIL single_ready: got %b want 0", oCMDReady); end
        total++; if (oACG_Command !== 8'h08) begin bad++; $display("FAIL single_command: got %h want 08", oACG_Command); end
        total++; if (dut_acg !== exp_acg(2)) begin bad++; $display("FAIL single_acg_slice: got %h want %h", dut_acg, exp_acg(2)); end
        total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", oBusy); end
        // Payload change mid-grant must reach the ACG in the same cycle.
        ex_cad[2] = 40'h12_3456_789A;
        #1;
        total++; if (oACG_CAData !== 40'h12_3456_789A) begin bad++; $display("FAIL single_zero_latency: got %h want 123456789a", oACG_CAData); end
        iACG_Ready    = 8'hFF;
        iACG_LastStep = 8'h5A;
        #1;
        total++; if (oCmd_ACG_Ready !== 32'h00FF_0000) begin bad++; $display("FAIL isolation_ready: got %h want 00ff0000", oCmd_ACG_Ready); end
        total++; if (oCmd_ACG_LastStep !== 32'h005A_0000) begin bad++; $display("FAIL isolation_laststep: got %h want 005a0000", oCmd_ACG_LastStep); end
        iCmd_LastStep = 4'b0100;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_multi_hit_and_release();
        randomize_execs();
        iCMDValid  = 1'b1;
        iCmd_Start = 4'b1010;
        step();
        iCMDValid  = 1'b0;
        iCmd_Start = '0;
        exp_multi  = 1'b1;
        #1;
        total++; if (oGrant !== 4'b0010) begin bad++; $display("FAIL multi_grant: got %b want 0010", oGrant); end
        total++; if (oMultiHit !== 1'b1) begin bad++; $display("FAIL multi_flag: got %b want 1", oMultiHit); end
        iCmd_LastStep = 4'b1000;
        step();
        total++; if ({oBusy, oGrant} !== 5'b1_0010) begin bad++; $display("FAIL release_foreign_laststep: got %b want 10010", {oBusy, oGrant}); end
        iCmd_LastStep = 4'b0010;
        step();
        iCmd_LastStep = '0;
        iACG_Ready    = 8'hFF;
        iACG_LastStep = 8'hFF;
        #1;
        total++; if (dut_acg !== ACG_IDLE) begin bad++; $display("FAIL release_acg_idle: got %h want %h", dut_acg, ACG_IDLE); end
        total++; if ({oCmd_ACG_Ready, oCmd_ACG_LastStep} !== 64'h0) begin bad++; $display("FAIL release_slices: got %h want 0", {oCmd_ACG_Ready, oCmd_ACG_LastStep}); end
        total++; if ({oBusy, oCMDReady} !== 2'b10) begin bad++; $display("FAIL release_busy_ready: got %b want 10", {oBusy, oCMDReady}); end
        step();
        total++; if ({oBusy, oCMDReady} !== 2'b01) begin bad++; $display("FAIL release_to_idle: got %b want 01", {oBusy, oCMDReady}); end
        total++; if (oMultiHit !== 1'b1) begin bad++; $display("FAIL multi_sticky: got %b want 1", oMultiHit); end
        idle_inputs();
    endtask

    task automatic test_no_hit();
        iCMDValid  = 1'b1;
        iCmd_Start = '0;
        step();
        iCMDValid = 1'b0;
        #1;
        total++; if (oNoHit !== 1'b1) begin bad++; $display("FAIL nohit_pulse: got %b want 1", oNoHit); end
        total++; if ({oBusy, oCMDReady, oGrant} !== 6'b01_0000) begin bad++; $display("FAIL nohit_stay_idle: got %b want 010000", {oBusy, oCMDReady, oGrant}); end
        step();
        total++; if (oNoHit !== 1'b0) begin bad++; $display("FAIL nohit_one_cycle: got %b want 0", oNoHit); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [NC-1:0] mask;
            int            w;
            int            hold;
            randomize_execs();
            for (int c = 0, n = $urandom_range(0, 2); c < n; c++) begin
                iCMDValid  = 1'b0;
                iCmd_Start = 4'($urandom);
                step();
                total++; if ({oBusy, oGrant} !== 5'b0) begin bad++; $display("FAIL rnd_no_valid_no_grant: got %b want 00000", {oBusy, oGrant}); end
            end
            mask       = 4'($urandom);
            w          = lowest_bit(mask);
            iCMDValid  = 1'b1;
            iCmd_Start = mask;
            #1;
            total++; if ({oCMDReady, oCmd_CMDValid} !== 5'b1_1111) begin bad++; $display("FAIL rnd_idle_offer: got %b want 11111", {oCMDReady, oCmd_CMDValid}); end
            step();
            idle_inputs();
            #1;
            if (w < 0) begin
                total++; if ({oNoHit, oBusy} !== 2'b10) begin bad++; $display("FAIL rnd_nohit: got %b want 10", {oNoHit, oBusy}); end
                step();
                continue;
            end
            if ($countones(mask) > 1) exp_multi = 1'b1;
            total++; if (oGrant !== 4'(1 << w)) begin bad++; $display("FAIL rnd_grant: mask %b got %b want %b", mask, oGrant, 4'(1 << w)); end
            total++; if (oMultiHit !== exp_multi) begin bad++; $display("FAIL rnd_multihit: got %b want %b", oMultiHit, exp_multi); end
            hold = $urandom_range(0, 5);
            for (int c = 0; c <= hold; c++) begin
                logic [NC-1:0] noise;
                noise         = 4'($urandom) & ~4'(1 << w);
                iCMDValid     = 1'($urandom);
                iCmd_Start    = 4'($urandom);
                iACG_Ready    = 8'($urandom);
                iACG_LastStep = 8'($urandom);
                iCmd_LastStep = (c == hold) ? (noise | 4'(1 << w)) : noise;
                #1;
                total++; if (dut_acg !== exp_acg(w)) begin bad++; $display("FAIL rnd_acg_mux: owner %0d got %h want %h", w, dut_acg, exp_acg(w)); end
                total++; if (oCmd_ACG_Ready !== exp_slices(w, iACG_Ready)) begin bad++; $display("FAIL rnd_ready_route: got %h want %h", oCmd_ACG_Ready, exp_slices(w, iACG_Ready)); end
                total++; if (oCmd_ACG_LastStep !== exp_slices(w, iACG_LastStep)) begin bad++; $display("FAIL rnd_last_route: got %h want %h", oCmd_ACG_LastStep, exp_slices(w, iACG_LastStep)); end
                total++; if ({oCMDReady, oCmd_CMDValid, oGrant} !== {5'b0_0000, 4'(1 << w)}) begin bad++; $display("FAIL rnd_grant_hold: got %b", {oCMDReady, oCmd_CMDValid, oGrant}); end
                step();
            end
            idle_inputs();
            iACG_Ready = 8'($urandom);
            #1;
            total++; if ({dut_acg, oCmd_ACG_Ready} !== {ACG_IDLE, 32'h0}) begin bad++; $display("FAIL rnd_release_idle: got %h %h", dut_acg, oCmd_ACG_Ready); end
            total++; if ({oBusy, oCMDReady, oGrant} !== 6'b10_0000) begin bad++; $display("FAIL rnd_release_state: got %b want 100000", {oBusy, oCMDReady, oGrant}); end
            step();
            total++; if ({oBusy, oCMDReady, oTimeout} !== {2'b01, exp_timeout}) begin bad++; $display("FAIL rnd_back_idle: got %b want 01%b", {oBusy, oCMDReady, oTimeout}, exp_timeout); end
        end
    endtask

    task automatic test_watchdog();
        randomize_execs();
        iCMDValid  = 1'b1;
        iCmd_Start = 4'b0001;
        step();
        idle_inputs();
`ifdef NFC_ARB_WATCHDOG_EN
        for (int n = 1; n <= int'(WD); n++) begin
            total++; if ({oBusy, oGrant, oTimeout} !== 6'b1_0001_0) begin bad++; $display("FAIL wd_still_granted: cycle %0d got %b want 100010", n, {oBusy, oGrant, oTimeout}); end
            step();
        end
        exp_timeout = 1'b1;
        total++; if ({oBusy, oGrant, oACG_CASelect, oTimeout} !== 7'b1_0000_1_1) begin bad++; $display("FAIL wd_release: got %b want 1000011", {oBusy, oGrant, oACG_CASelect, oTimeout}); end
        step();
        total++; if ({oCMDReady, oTimeout} !== 2'b11) begin bad++; $display("FAIL wd_sticky: got %b want 11", {oCMDReady, oTimeout}); end
`else
        for (int n = 1; n <= int'(WD) + 4; n++) step();
        total++; if ({oBusy, oGrant, oTimeout} !== 6'b1_0001_0) begin bad++; $display("FAIL nowd_hold: got %b want 100010", {oBusy, oGrant, oTimeout}); end
        iCmd_LastStep = 4'b0001;
        step();
        idle_inputs();
        step();
        total++; if ({oCMDReady, oTimeout} !== 2'b10) begin bad++; $display("FAIL nowd_release: got %b want 10", {oCMDReady, oTimeout}); end
`endif
    endtask

    task automatic test_mid_grant_reset();
        randomize_execs();
        iCMDValid  = 1'b1;
        iCmd_Start = 4'b1000;
        step();
        idle_inputs();
        total++; if (oGrant !== 4'b1000) begin bad++; $display("FAIL midrst_grant: got %b want 1000", oGrant); end
        iReset = 1'b1;
        step();
        iReset      = 1'b0;
        exp_multi   = 1'b0;
        exp_timeout = 1'b0;
        total++; if ({oGrant, oBusy, oCMDReady} !== 6'b0000_0_1) begin bad++; $display("FAIL midrst_idle: got %b want 000001", {oGrant, oBusy, oCMDReady}); end
        total++; if (dut_acg !== ACG_IDLE) begin bad++; $display("FAIL midrst_acg: got %h want %h", dut_acg, ACG_IDLE); end
        total++; if ({oMultiHit, oTimeout} !== 2'b00) begin bad++; $display("FAIL midrst_flags: got %b want 00", {oMultiHit, oTimeout}); end
        step();
        total++; if ({oBusy, oCMDReady} !== 2'b01) begin bad++; $display("FAIL midrst_no_release: got %b want 01", {oBusy, oCMDReady}); end
    endtask

    initial begin
        #500000;
        $display("FAIL sim_time_limit: run exceeded bound");
        $fatal(1);
    end

    initial begin
        iReset = 1'b1;
        idle_inputs();
        for (int k = 0; k < NC; k++) begin
            ex_cmd[k] = '0; ex_opt[k] = '0; ex_way[k] = '0;
            ex_nd[k]  = '0; ex_cas[k] = '0; ex_cad[k] = '0;
        end
        test_reset();
        test_single_and_isolation();
        test_multi_hit_and_release();
        test_no_hit();
        test_random();
        test_watchdog();
        test_mid_grant_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
